// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types for the LSU-to-data-memory controller.
// Size codes follow the RISC-V load/store funct3 field.
package riscv_pkg;

    typedef enum logic [2:0] {
        LDST_B  = 3'b000,
        LDST_H  = 3'b001,
        LDST_W  = 3'b010,
        LDST_BU = 3'b100,
        LDST_HU = 3'b101
    } ldst_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    // Only the five load codes exist; stores use just B/H/W.
    function automatic logic size_ok(
        input logic [2:0] size,
        input logic       we
    );
        logic ok;
        case (size)
            LDST_B, LDST_H, LDST_W: ok = 1'b1;
            LDST_BU, LDST_HU:       ok = !we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request and word-memory bus of the load/store controller.
// The controller takes the slave view; the core/memory side is master.
interface lsu_mem_ctrl_if;

    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_wd_o;
    logic        mem_we_o;
    logic [31:0] mem_rd_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i,
        input  core_addr_i, core_wd_i, mem_rd_i,
        output core_rd_o, core_stall_o, misalign_o,
        output mem_a_o, mem_wd_o, mem_we_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i,
        output core_addr_i, core_wd_i, mem_rd_i,
        input  core_rd_o, core_stall_o, misalign_o,
        input  mem_a_o, mem_wd_o, mem_we_o
    );

endinterface

// File: rtl/lsu_mem_ctrl_byte_lane.sv
// Byte/half lane logic: extract+extend for loads, merge for sub-word stores.
// Purely combinational; offset is already forced aligned by the caller.
module lsu_byte_lane
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*off +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = '0;
        st_data = rdata;
        case (size)
            LDST_B: begin
                ld_data = {{24{byte_sel[7]}}, byte_sel};
                st_data[8*off +: 8] = wdata[7:0];
            end
            LDST_H: begin
                ld_data = {{16{half_sel[15]}}, half_sel};
                if (off[1]) st_data[31:16] = wdata[15:0];
                else        st_data[15:0]  = wdata[15:0];
            end
            LDST_W: begin
                ld_data = rdata;
                st_data = wdata;
            end
            LDST_BU: ld_data = {24'h0, byte_sel};
            LDST_HU: ld_data = {16'h0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-only data memory.
// Sub-word stores become a stalled read-modify-write over two cycles.
module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_mem_ctrl_if.slave bus
);

    lsu_state_e  state_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;

    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] word_addr;
    logic        we;
    logic        is_h;
    logic        is_w;
    logic        bad_off;
    logic        misal;
    logic        act;
    logic        go;
    logic        sw_go;
    logic        sub_go;
    logic [1:0]  off;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign size      = bus.core_size_i;
    assign addr      = bus.core_addr_i;
    assign we        = bus.core_we_i;
    assign word_addr = {addr[31:2], 2'b00};

    assign is_h    = size[1:0] == 2'b01;
    assign is_w    = size[1:0] == 2'b10;
    assign bad_off = (is_h && addr[0]) || (is_w && addr[1:0] != 2'b00);
    assign misal   = !size_ok(size, we) || (ALIGN_CHECK && bad_off);

    // Without alignment checking the low offset bits are simply ignored.
    assign off = is_w ? 2'b00 :
                 is_h ? {addr[1], 1'b0} :
                        addr[1:0];

    assign act    = bus.core_req_i && state_q == IDLE && !rst_i;
    assign go     = act && !misal;
    assign sw_go  = go && we && is_w;
    assign sub_go = go && we && !is_w;

    lsu_byte_lane u_lane (
        .size    (size),
        .off     (off),
        .rdata   (bus.mem_rd_i),
        .wdata   (bus.core_wd_i),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_comb begin
        bus.mem_a_o      = '0;
        bus.mem_wd_o     = '0;
        bus.mem_we_o     = 1'b0;
        bus.core_stall_o = 1'b0;
        bus.core_rd_o    = '0;
        bus.misalign_o   = 1'b0;
        if (!rst_i) begin
            if (state_q == RMW_WR) begin
                bus.mem_a_o  = wr_addr_q;
                bus.mem_wd_o = wr_data_q;
                bus.mem_we_o = 1'b1;
            end else begin
                bus.mem_a_o      = word_addr;
                bus.mem_wd_o     = sw_go ? bus.core_wd_i : '0;
                bus.mem_we_o     = sw_go;
                bus.core_stall_o = sub_go;
                bus.core_rd_o    = (go && !we) ? ld_data : '0;
                bus.misalign_o   = act && misal;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sub_go) begin
                        state_q   <= RMW_WR;
                        wr_addr_q <= word_addr;
                        wr_data_q <= st_data;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized scoreboard bench for lsu_mem_ctrl against a word-array memory.
// Expected writes/loads/rejects are queued at issue and popped by a monitor.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

    localparam logic [31:0] BASE = 32'h8800_0000;
    localparam int          NW   = 64;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.ALIGN_CHECK(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];

    function automatic logic in_rng(input logic [31:0] a);
        return a >= BASE && a < BASE + 32'(NW * 4);
    endfunction

    always_comb bus.mem_rd_i = in_rng(bus.mem_a_o) ? mem[bus.mem_a_o[7:2]] : 32'h0;

    always @(posedge clk)
        if (bus.mem_we_o && in_rng(bus.mem_a_o)) mem[bus.mem_a_o[7:2]] = bus.mem_wd_o;

    wr_t         exp_wr [$];
    logic [31:0] exp_ld [$];
    logic [31:0] exp_mis[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with nothing expected (t=%0t)", nm, $time);
    endtask

    // Monitor: pops one expectation per DUT event.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (bus.mem_we_o) begin
                if (exp_wr.size() == 0) unexpected("mem write");
                else begin
                    e = exp_wr.pop_front();
                    check("write addr", bus.mem_a_o, e.a);
                    check("write data", bus.mem_wd_o, e.d);
                end
            end
            if (bus.misalign_o) begin
                if (exp_mis.size() == 0) unexpected("misalign");
                else check("misalign addr", bus.core_addr_i, exp_mis.pop_front());
            end
            if (bus.core_req_i && !bus.core_we_i && !bus.misalign_o && !bus.core_stall_o) begin
                if (exp_ld.size() == 0) unexpected("load");
                else check("load data", bus.core_rd_o, exp_ld.pop_front());
            end
        end
    end

    function automatic logic [31:0] ref_load(
        input logic [31:0] w, input logic [2:0] sz, input logic [1:0] o
    );
        int unsigned s;
        int          v;
        s = w >> (8 * o);
        case (sz)
            3'b000: begin v = int'(s % 256);   if (v >= 128)   v -= 256;   end
            3'b001: begin v = int'(s % 65536); if (v >= 32768) v -= 65536; end
            3'b100: v = int'(s % 256);
            3'b101: v = int'(s % 65536);
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    task automatic issue(
        input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd
    );
        logic [31:0] wa, w, nw, m;
        logic [1:0]  o;
        bit          ok, mis, st;
        int          exp_st, st_n;
        wa = {a[31:2], 2'b00};
        o  = a[1:0];
        ok  = (sz == 3'd0 || sz == 3'd1 || sz == 3'd2) ||
              (!we && (sz == 3'd4 || sz == 3'd5));
        mis = !ok || (sz == 3'd1 && a[0]) || (sz == 3'd5 && a[0]) ||
              (sz == 3'd2 && o != 2'b00);
        w = in_rng(wa) ? ref_mem[wa[7:2]] : 32'h0;
        exp_st = 0;
        if (mis) exp_mis.push_back(a);
        else if (!we) exp_ld.push_back(ref_load(w, sz, o));
        else begin
            if (sz == 3'd2) nw = wd;
            else begin
                m  = (sz == 3'd0) ? 32'hFF : 32'hFFFF;
                nw = (w & ~(m << (8 * o))) | ((wd & m) << (8 * o));
                exp_st = 1;
            end
            exp_wr.push_back(wr_t'{a: wa, d: nw});
            if (in_rng(wa)) ref_mem[wa[7:2]] = nw;
        end
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = sz;
        bus.core_addr_i = a;
        bus.core_wd_i   = wd;
        st_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            st = bus.core_stall_o;
            if (st) st_n++;
            @(posedge clk);
            #1;
            if (!st) break;
        end
        check("stall cycles", 32'(st_n), 32'(exp_st));
        bus.core_req_i = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'($urandom);
        bus.core_size_i = 3'($urandom);
        bus.core_addr_i = BASE + 32'($urandom_range(0, NW * 4 - 1));
        @(negedge clk);
        check("idle rd", bus.core_rd_o, 32'h0);
        check("idle stall", {31'h0, bus.core_stall_o}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, w0;
        logic [2:0]  szs [8];
        int          c0;
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        for (int i = 0; i < NW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b1;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = BASE + 32'h10;
        bus.core_wd_i   = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check("reset we",    {31'h0, bus.mem_we_o},     32'h0);
        check("reset stall", {31'h0, bus.core_stall_o}, 32'h0);
        check("reset mis",   {31'h0, bus.misalign_o},   32'h0);
        check("reset addr",  bus.mem_a_o,  32'h0);
        check("reset wd",    bus.mem_wd_o, 32'h0);
        check("reset rd",    bus.core_rd_o, 32'h0);
        bus.core_req_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b1, 3'd2, BASE + 32'h4, 32'hDEAD_BEEF);
        issue(1'b1, 3'd0, BASE + 32'h5, 32'h0000_00AA);
        issue(1'b0, 3'd2, BASE + 32'h4, 32'h0);
        issue(1'b1, 3'd2, BASE + 32'h4, 32'hDEAD_BEEF);
        issue(1'b0, 3'd0, BASE + 32'h7, 32'h0);
        issue(1'b0, 3'd4, BASE + 32'h7, 32'h0);
        issue(1'b0, 3'd1, BASE + 32'h6, 32'h0);
        issue(1'b0, 3'd5, BASE + 32'h4, 32'h0);
        issue(1'b1, 3'd1, BASE + 32'h3, 32'h0000_5555);
        issue(1'b0, 3'd2, BASE + 32'h0, 32'h0);

        // Reset pulsed during the write cycle of a half store.
        w0 = ref_mem[2];
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b1;
        bus.core_size_i = 3'd1;
        bus.core_addr_i = BASE + 32'h8;
        bus.core_wd_i   = 32'h0000_CAFE;
        @(negedge clk);
        check("rmw c0 stall", {31'h0, bus.core_stall_o}, 32'h1);
        @(posedge clk);
        #1;
        check("rmw c1 we", {31'h0, bus.mem_we_o}, 32'h1);
        rst = 1'b1;
        bus.core_req_i = 1'b0;
        #1;
        check("rst mid-rmw we",    {31'h0, bus.mem_we_o},     32'h0);
        check("rst mid-rmw stall", {31'h0, bus.core_stall_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst word kept", mem[2], w0);
        issue(1'b0, 3'd2, BASE + 32'h8, 32'h0);
        issue(1'b1, 3'd2, BASE + 32'h8, 32'h0BAD_F00D);
        issue(1'b0, 3'd2, BASE + 32'h8, 32'h0);

        c0 = cyc;
        issue(1'b1, 3'd0, BASE + 32'hC, 32'h11);
        issue(1'b1, 3'd0, BASE + 32'hD, 32'h22);
        issue(1'b1, 3'd0, BASE + 32'hE, 32'h33);
        issue(1'b1, 3'd0, BASE + 32'hF, 32'h44);
        check("b2b cycles", 32'(cyc - c0), 32'd8);
        issue(1'b0, 3'd2, BASE + 32'hC, 32'h0);
        check("b2b word", mem[3], 32'h4433_2211);

        issue(1'b1, 3'd0, 32'h9000_0001, 32'h77);
        issue(1'b0, 3'd0, 32'h9000_0001, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) idle_cycle();
            else begin
                if ($urandom_range(0, 9) == 0) a = 32'h9000_0000 + 32'($urandom_range(0, 255));
                else a = BASE + 32'($urandom_range(0, NW * 4 - 1));
                issue(1'($urandom), szs[$urandom_range(0, 7)], a, $urandom);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NW; i++) check("final mem", mem[i], ref_mem[i]);
        check("wr queue left",  32'(exp_wr.size()),  32'h0);
        check("ld queue left",  32'(exp_ld.size()),  32'h0);
        check("mis queue left", 32'(exp_mis.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
